// File: rtl/alu_issue.sv
//==============================================================================
// Module   : alu_issue
// Purpose  : ID-stage decode, operand forwarding, hazard stall and ID/EX
//            pipeline register for a 5-stage MIPS-style integer pipeline.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_issue #(
    parameter int FWD_EN = 1
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] inst,
    input  logic        id_valid,
    input  logic        flush,
    input  logic [31:0] qa,
    input  logic [31:0] qb,
    input  logic        ex_wreg,
    input  logic        ex_m2reg,
    input  logic [4:0]  ex_rn,
    input  logic [31:0] ex_alu,
    input  logic        mm_wreg,
    input  logic        mm_m2reg,
    input  logic [4:0]  mm_rn,
    input  logic [31:0] mm_alu,
    input  logic [31:0] mm_mo,
    output logic        stall,
    output logic        e_valid,
    output logic        e_wreg,
    output logic        e_m2reg,
    output logic        e_wmem,
    output logic [3:0]  e_aluc,
    output logic [4:0]  e_rn,
    output logic [31:0] e_a,
    output logic [31:0] e_b,
    output logic [31:0] e_d
);

    // ALU control encodings
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    // Operand-B source selection
    localparam logic [1:0] BSEL_RT   = 2'd0;
    localparam logic [1:0] BSEL_SEXT = 2'd1;
    localparam logic [1:0] BSEL_ZEXT = 2'd2;
    localparam logic [1:0] BSEL_LUI  = 2'd3;

    // Instruction fields
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm;

    assign op    = inst[31:26];
    assign rs    = inst[25:21];
    assign rt    = inst[20:16];
    assign rd    = inst[15:11];
    assign sa    = inst[10:6];
    assign funct = inst[5:0];
    assign imm   = inst[15:0];

    // Decoded controls
    logic       dec_legal;
    logic       dec_is_r;
    logic       dec_shift;
    logic       dec_lui;
    logic       dec_m2reg;
    logic       dec_wmem;
    logic [3:0] dec_aluc;
    logic [1:0] dec_bsel;
    logic       dec_use_rs;
    logic       dec_use_rt;
    logic [4:0] dec_rn;
    logic       dec_wreg;

    // Decode the opcode/funct into ALU and writeback controls
    always_comb begin
        dec_legal  = 1'b0;
        dec_is_r   = 1'b0;
        dec_shift  = 1'b0;
        dec_lui    = 1'b0;
        dec_m2reg  = 1'b0;
        dec_wmem   = 1'b0;
        dec_aluc   = ALU_ADD;
        dec_bsel   = BSEL_RT;
        dec_use_rs = 1'b0;
        dec_use_rt = 1'b0;
        case (op)
            6'b000000: begin
                dec_is_r   = 1'b1;
                dec_legal  = 1'b1;
                dec_use_rs = 1'b1;
                dec_use_rt = 1'b1;
                case (funct)
                    6'b100000: dec_aluc = ALU_ADD;
                    6'b100010: dec_aluc = ALU_SUB;
                    6'b100100: dec_aluc = ALU_AND;
                    6'b100101: dec_aluc = ALU_OR;
                    6'b100110: dec_aluc = ALU_XOR;
                    6'b000000: begin dec_aluc = ALU_SLL; dec_shift = 1'b1; dec_use_rs = 1'b0; end
                    6'b000010: begin dec_aluc = ALU_SRL; dec_shift = 1'b1; dec_use_rs = 1'b0; end
                    6'b000011: begin dec_aluc = ALU_SRA; dec_shift = 1'b1; dec_use_rs = 1'b0; end
                    default: begin
                        // Unknown funct behaves as a nop that reads nothing
                        dec_legal  = 1'b0;
                        dec_use_rs = 1'b0;
                        dec_use_rt = 1'b0;
                    end
                endcase
            end
            6'b001000: begin dec_legal = 1'b1; dec_use_rs = 1'b1; dec_aluc = ALU_ADD; dec_bsel = BSEL_SEXT; end
            6'b001100: begin dec_legal = 1'b1; dec_use_rs = 1'b1; dec_aluc = ALU_AND; dec_bsel = BSEL_ZEXT; end
            6'b001101: begin dec_legal = 1'b1; dec_use_rs = 1'b1; dec_aluc = ALU_OR;  dec_bsel = BSEL_ZEXT; end
            6'b001110: begin dec_legal = 1'b1; dec_use_rs = 1'b1; dec_aluc = ALU_XOR; dec_bsel = BSEL_ZEXT; end
            6'b001111: begin dec_legal = 1'b1; dec_lui = 1'b1;    dec_aluc = ALU_ADD; dec_bsel = BSEL_LUI;  end
            6'b100011: begin
                dec_legal  = 1'b1;
                dec_use_rs = 1'b1;
                dec_m2reg  = 1'b1;
                dec_bsel   = BSEL_SEXT;
            end
            6'b101011: begin
                dec_legal  = 1'b1;
                dec_use_rs = 1'b1;
                dec_use_rt = 1'b1;
                dec_wmem   = 1'b1;
                dec_bsel   = BSEL_SEXT;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign dec_rn   = dec_is_r ? rd : rt;
    assign dec_wreg = dec_legal & ~dec_wmem & (dec_rn != 5'd0);

    // Pick the freshest value of a source register from EX, MEM or the file
    function automatic logic [31:0] fwd_src(input logic [4:0] r, input logic [31:0] rf);
        logic [31:0] v;
        v = rf;
        if ((FWD_EN != 0) && (r != 5'd0)) begin
            if (ex_wreg && !ex_m2reg && (ex_rn == r)) begin
                v = ex_alu;
            end else if (mm_wreg && (mm_rn == r)) begin
                v = mm_m2reg ? mm_mo : mm_alu;
            end
        end
        return v;
    endfunction

    // True when register r cannot be supplied this cycle and ID must wait
    function automatic logic hazard(input logic [4:0] r);
        logic h;
        h = 1'b0;
        if (r != 5'd0) begin
            if (ex_wreg && ex_m2reg && (ex_rn == r)) begin
                h = 1'b1;
            end
            if ((FWD_EN == 0) && ((ex_wreg && (ex_rn == r)) || (mm_wreg && (mm_rn == r)))) begin
                h = 1'b1;
            end
        end
        return h;
    endfunction

    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        load;

    assign fwd_a = fwd_src(rs, qa);
    assign fwd_b = fwd_src(rt, qb);

    // Stall only for a live ID instruction; a flush overrides the stall
    assign stall = id_valid & ~flush &
                   ((dec_use_rs & hazard(rs)) | (dec_use_rt & hazard(rt)));

    assign load = id_valid & ~flush & ~stall;

    // Select ALU operands from shift amount, immediates or forwarded data
    always_comb begin
        opa = fwd_a;
        if (dec_shift) begin
            opa = {27'd0, sa};
        end else if (dec_lui) begin
            opa = 32'd0;
        end
        case (dec_bsel)
            BSEL_SEXT: opb = {{16{imm[15]}}, imm};
            BSEL_ZEXT: opb = {16'd0, imm};
            BSEL_LUI:  opb = {imm, 16'd0};
            default:   opb = fwd_b;
        endcase
    end

    // Next ID/EX contents: decoded instruction or a bubble
    logic        valid_d, wreg_d, m2reg_d, wmem_d;
    logic [3:0]  aluc_d;
    logic [4:0]  rn_d;
    logic [31:0] a_d, b_d, d_d;

    always_comb begin
        valid_d = load;
        wreg_d  = load & dec_wreg;
        m2reg_d = load & dec_legal & dec_m2reg;
        wmem_d  = load & dec_legal & dec_wmem;
        aluc_d  = (load & dec_legal) ? dec_aluc : ALU_ADD;
        rn_d    = load ? dec_rn : 5'd0;
        a_d     = load ? opa : 32'd0;
        b_d     = load ? opb : 32'd0;
        d_d     = load ? fwd_b : 32'd0;
    end

    logic        valid_q, wreg_q, m2reg_q, wmem_q;
    logic [3:0]  aluc_q;
    logic [4:0]  rn_q;
    logic [31:0] a_q, b_q, d_q;

    // ID/EX pipeline register with asynchronous clear
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            valid_q <= 1'b0;
            wreg_q  <= 1'b0;
            m2reg_q <= 1'b0;
            wmem_q  <= 1'b0;
            aluc_q  <= 4'd0;
            rn_q    <= 5'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            d_q     <= 32'd0;
        end else begin
            valid_q <= valid_d;
            wreg_q  <= wreg_d;
            m2reg_q <= m2reg_d;
            wmem_q  <= wmem_d;
            aluc_q  <= aluc_d;
            rn_q    <= rn_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
        end
    end

    assign e_valid = valid_q;
    assign e_wreg  = wreg_q;
    assign e_m2reg = m2reg_q;
    assign e_wmem  = wmem_q;
    assign e_aluc  = aluc_q;
    assign e_rn    = rn_q;
    assign e_a     = a_q;
    assign e_b     = b_q;
    assign e_d     = d_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
//==============================================================================
// Module   : tb_alu_issue
// Purpose  : Scoreboard bench for alu_issue, forwarding on and off instances
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_issue;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic [31:0] inst = 32'd0;
    logic        id_valid = 1'b0, flush = 1'b0;
    logic [31:0] qa = 32'd0, qb = 32'd0;
    logic        ex_wreg = 1'b0, ex_m2reg = 1'b0;
    logic [4:0]  ex_rn = 5'd0;
    logic [31:0] ex_alu = 32'd0;
    logic        mm_wreg = 1'b0, mm_m2reg = 1'b0;
    logic [4:0]  mm_rn = 5'd0;
    logic [31:0] mm_alu = 32'd0, mm_mo = 32'd0;

    typedef struct packed {
        logic        v, w, m, s;
        logic [3:0]  c;
        logic [4:0]  rn;
        logic [31:0] a, b, d;
    } out_t;

    typedef struct {
        out_t o;
        bit   nop;
    } exp_t;

    out_t got1, got0;
    logic stall1, stall0;

    alu_issue #(.FWD_EN(1)) dut1 (
        .clk(clk), .clrn(clrn), .inst(inst), .id_valid(id_valid), .flush(flush),
        .qa(qa), .qb(qb), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn),
        .ex_alu(ex_alu), .mm_wreg(mm_wreg), .mm_m2reg(mm_m2reg), .mm_rn(mm_rn),
        .mm_alu(mm_alu), .mm_mo(mm_mo), .stall(stall1),
        .e_valid(got1.v), .e_wreg(got1.w), .e_m2reg(got1.m), .e_wmem(got1.s),
        .e_aluc(got1.c), .e_rn(got1.rn), .e_a(got1.a), .e_b(got1.b), .e_d(got1.d)
    );

    alu_issue #(.FWD_EN(0)) dut0 (
        .clk(clk), .clrn(clrn), .inst(inst), .id_valid(id_valid), .flush(flush),
        .qa(qa), .qb(qb), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn),
        .ex_alu(ex_alu), .mm_wreg(mm_wreg), .mm_m2reg(mm_m2reg), .mm_rn(mm_rn),
        .mm_alu(mm_alu), .mm_mo(mm_mo), .stall(stall0),
        .e_valid(got0.v), .e_wreg(got0.w), .e_m2reg(got0.m), .e_wmem(got0.s),
        .e_aluc(got0.c), .e_rn(got0.rn), .e_a(got0.a), .e_b(got0.b), .e_d(got0.d)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    exp_t q1[$];
    exp_t q0[$];

    // Instruction kinds: 0 add,1 sub,2 and,3 or,4 xor,5 sll,6 srl,7 sra,
    // 8 addi,9 andi,10 ori,11 xori,12 lui,13 lw,14 sw,15 nop
    function automatic logic [31:0] enc(int k, logic [4:0] rs, logic [4:0] rt,
                                        logic [4:0] rd, logic [4:0] sa, logic [15:0] imm);
        logic [5:0] f;
        logic [5:0] o;
        f = 6'h20; o = 6'h00;
        case (k)
            0: f = 6'h20;  1: f = 6'h22;  2: f = 6'h24;  3: f = 6'h25;
            4: f = 6'h26;  5: f = 6'h00;  6: f = 6'h02;  7: f = 6'h03;
            8: o = 6'h08;  9: o = 6'h0C;  10: o = 6'h0D; 11: o = 6'h0E;
            12: o = 6'h0F; 13: o = 6'h23; 14: o = 6'h2B;
            default: o = 6'h02;
        endcase
        if (k <= 7) return {6'd0, rs, rt, rd, sa, f};
        return {o, rs, rt, imm};
    endfunction

    // Newest committed-or-in-flight value of register r as seen from ID
    function automatic logic [31:0] src_val(bit fwd, logic [4:0] r, logic [31:0] rf);
        if (!fwd || r == 0) return rf;
        if (ex_wreg && !ex_m2reg && ex_rn == r) return ex_alu;
        if (mm_wreg && mm_rn == r) return mm_m2reg ? mm_mo : mm_alu;
        return rf;
    endfunction

    function automatic bit blocked(bit fwd, logic [4:0] r);
        if (r == 0) return 1'b0;
        if (ex_wreg && ex_m2reg && ex_rn == r) return 1'b1;
        if (!fwd && ((ex_wreg && ex_rn == r) || (mm_wreg && mm_rn == r))) return 1'b1;
        return 1'b0;
    endfunction

    int       cur_k;
    logic [4:0] cur_rs, cur_rt, cur_rd, cur_sa;
    logic [15:0] cur_imm;

    function automatic bit model_stall(bit fwd);
        bit use_rs, use_rt;
        use_rs = !(cur_k >= 5 && cur_k <= 7) && cur_k != 12 && cur_k != 15;
        use_rt = cur_k <= 7 || cur_k == 14;
        return id_valid && !flush &&
               ((use_rs && blocked(fwd, cur_rs)) || (use_rt && blocked(fwd, cur_rt)));
    endfunction

    function automatic exp_t model(bit fwd);
        exp_t e;
        int unsigned alu_tab [16] = '{0, 4, 1, 5, 2, 3, 7, 15, 0, 1, 5, 2, 0, 0, 0, 0};
        e.o = '0;
        e.nop = 1'b0;
        if (!id_valid || flush || model_stall(fwd)) return e;
        e.nop = (cur_k == 15);
        e.o.v = 1'b1;
        e.o.rn = (cur_k <= 7) ? cur_rd : cur_rt;
        e.o.w = (cur_k != 15) && (cur_k != 14) && (e.o.rn != 0);
        e.o.m = (cur_k == 13);
        e.o.s = (cur_k == 14);
        e.o.c = alu_tab[cur_k][3:0];
        if (cur_k >= 5 && cur_k <= 7) e.o.a = {27'd0, cur_sa};
        else if (cur_k == 12)         e.o.a = 32'd0;
        else                          e.o.a = src_val(fwd, cur_rs, qa);
        if (cur_k <= 7)                               e.o.b = src_val(fwd, cur_rt, qb);
        else if (cur_k == 8 || cur_k == 13 || cur_k == 14) e.o.b = 32'(signed'(cur_imm));
        else if (cur_k == 12)                         e.o.b = {cur_imm, 16'd0};
        else                                          e.o.b = {16'd0, cur_imm};
        e.o.d = src_val(fwd, cur_rt, qb);
        return e;
    endfunction

    task automatic check_stall(string nm, logic got, logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: stall got=%0b want=%0b", nm, got, exp);
        end
    endtask

    task automatic check_out(string nm, out_t g, exp_t e);
        bit ok;
        ok = (g.v === e.o.v) && (g.w === e.o.w) && (g.m === e.o.m) && (g.s === e.o.s) &&
             (g.c === e.o.c) && (g.d === e.o.d) &&
             (e.nop || ((g.a === e.o.a) && (g.b === e.o.b) && (g.rn === e.o.rn)));
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got v%0b w%0b m%0b s%0b c%h rn%0d a%h b%h d%h want v%0b w%0b m%0b s%0b c%h rn%0d a%h b%h d%h",
                     nm, g.v, g.w, g.m, g.s, g.c, g.rn, g.a, g.b, g.d,
                     e.o.v, e.o.w, e.o.m, e.o.s, e.o.c, e.o.rn, e.o.a, e.o.b, e.o.d);
        end
    endtask

    // Monitor: after every capture edge, pop the expected response and compare
    always @(posedge clk) begin
        #2;
        if (q1.size() > 0) check_out("ex_fwd1", got1, q1.pop_front());
        if (q0.size() > 0) check_out("ex_fwd0", got0, q0.pop_front());
    end

    // Drive one ID instruction at the falling edge and record expectations
    task automatic issue(int k, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                         logic [4:0] sa, logic [15:0] imm, logic v, logic fl);
        cur_k = k; cur_rs = rs; cur_rt = rt; cur_rd = rd; cur_sa = sa; cur_imm = imm;
        inst = enc(k, rs, rt, rd, sa, imm);
        id_valid = v;
        flush = fl;
        #1;
        check_stall("stall_fwd1", stall1, model_stall(1'b1));
        check_stall("stall_fwd0", stall0, model_stall(1'b0));
        q1.push_back(model(1'b1));
        q0.push_back(model(1'b0));
        @(negedge clk);
    endtask

    task automatic quiet_pipe();
        ex_wreg = 0; ex_m2reg = 0; ex_rn = 0; ex_alu = 0;
        mm_wreg = 0; mm_m2reg = 0; mm_rn = 0; mm_alu = 0; mm_mo = 0;
    endtask

    task automatic check_cleared(string nm);
        out_t z;
        exp_t e;
        z = '0;
        e.o = z;
        e.nop = 1'b0;
        check_out({nm, "_1"}, got1, e);
        check_out({nm, "_0"}, got0, e);
    endtask

    initial begin
        #3;
        check_cleared("reset");
        @(negedge clk);
        clrn = 1'b1;

        // Plain add with no hazards
        quiet_pipe(); qa = 5; qb = 7;
        issue(0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 1, 0);
        // EX forwarding of rs
        ex_wreg = 1; ex_rn = 3; ex_alu = 12; qa = 99; qb = 1;
        issue(1, 5'd3, 5'd1, 5'd4, 5'd0, 16'd0, 1, 0);
        // Load-use: stall then resolve through MEM load data
        quiet_pipe(); ex_wreg = 1; ex_m2reg = 1; ex_rn = 5; qa = 77; qb = 0;
        issue(0, 5'd5, 5'd0, 5'd6, 5'd0, 16'd0, 1, 0);
        quiet_pipe(); mm_wreg = 1; mm_m2reg = 1; mm_rn = 5; mm_mo = 32'h1234;
        issue(0, 5'd5, 5'd0, 5'd6, 5'd0, 16'd0, 1, 0);
        // Arithmetic shift and lui operand shaping
        quiet_pipe(); qa = 32'h55; qb = 32'h8000_0000;
        issue(7, 5'd0, 5'd2, 5'd7, 5'd3, 16'd0, 1, 0);
        issue(12, 5'd0, 5'd8, 5'd0, 5'd0, 16'hABCD, 1, 0);
        // Flush overrides a load-use stall
        ex_wreg = 1; ex_m2reg = 1; ex_rn = 5;
        issue(0, 5'd5, 5'd0, 5'd6, 5'd0, 16'd0, 1, 1);
        // ori against a MEM producer: forwarded on one instance, stalled on the other
        quiet_pipe(); mm_wreg = 1; mm_rn = 3; mm_alu = 32'h0F0F; qa = 32'h1;
        issue(10, 5'd3, 5'd9, 5'd0, 5'd0, 16'hFFFF, 1, 0);
        quiet_pipe();
        issue(10, 5'd3, 5'd9, 5'd0, 5'd0, 16'hFFFF, 1, 0);
        // Store and load with negative offset, and an invalid slot
        ex_wreg = 1; ex_rn = 4; ex_alu = 32'hCAFE;
        issue(14, 5'd2, 5'd4, 5'd0, 5'd0, 16'hFFF8, 1, 0);
        issue(13, 5'd4, 5'd6, 5'd0, 5'd0, 16'h8000, 1, 0);
        issue(0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 0, 0);

        // Asynchronous clear in the middle of a load-use stall
        ex_wreg = 1; ex_m2reg = 1; ex_rn = 5;
        issue(0, 5'd5, 5'd0, 5'd6, 5'd0, 16'd0, 1, 0);
        issue(3, 5'd1, 5'd5, 5'd6, 5'd0, 16'd0, 1, 0);
        @(posedge clk);
        #3;
        clrn = 1'b0;
        #1;
        check_cleared("async_clr");
        check_stall("stall_in_reset", stall1, 1'b1);
        @(negedge clk);
        clrn = 1'b1;

        // Randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            ex_wreg = 1'($urandom); ex_m2reg = 1'($urandom);
            ex_rn = 5'($urandom_range(0, 7)); ex_alu = $urandom;
            mm_wreg = 1'($urandom); mm_m2reg = 1'($urandom);
            mm_rn = 5'($urandom_range(0, 7)); mm_alu = $urandom; mm_mo = $urandom;
            qa = $urandom; qb = $urandom;
            issue(int'($urandom_range(0, 15)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom), 16'($urandom),
                  ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0));
        end

        repeat (3) @(negedge clk);
        total++;
        if (q1.size() != 0 || q0.size() != 0) begin
            bad++;
            $display("FAIL drain: pending got=%0d want=0", q1.size() + q0.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter FWD_EN, default 1, 1 = EX/MEM result forwarding enabled; 0 = stall on every RAW hazard against EX or MEM.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 clrn  input  1  reset, asynchronous and active-low.
REQ-004 inst  input  32  ID-stage MIPS instruction.
REQ-005 id_valid  input  1  inst is valid.
REQ-006 flush  input  1  kill ID instruction (taken branch).
REQ-007 qa, qb  input  32 each  register-file read data for rs, rt.
REQ-008 ex_wreg, ex_m2reg  input  1 each; ex_rn  input  5; ex_alu  input  32  EX-stage writeback info and result.
REQ-009 mm_wreg, mm_m2reg  input  1 each; mm_rn  input  5; mm_alu, mm_mo  input  32 each  MEM-stage writeback info, ALU result, load data.
REQ-010 stall  output  1  combinational; holds PC and IF/ID.
REQ-011 e_valid, e_wreg, e_m2reg, e_wmem  output  1 each  registered EX controls.
REQ-012 e_aluc  output  4  registered ALU control; e_rn  output  5  destination register.
REQ-013 e_a, e_b, e_d  output  32 each  registered ALU operands and store data.

Function
REQ-014 ALU encoding: ADD 0000, SUB 0100, AND 0001, OR 0101, XOR 0010, SLL 0011, SRL 0111, SRA 1111.
REQ-015 Decode: R-type funct add/sub/and/or/xor/sll/srl/sra; I-type addi, andi, ori, xori, lui, lw, sw; any other encoding is a nop (e_wreg=0, e_wmem=0, e_aluc=0000).
REQ-016 e_rn = rd for R-type, rt for I-type; e_wreg=0 whenever e_rn would be 0 or op is sw.
REQ-017 Operand A: shifts -> {27'b0, sa}; lui -> 0; else forwarded rs.
REQ-018 Operand B: R-type -> forwarded rt; addi/lw/sw -> sign-extended imm; andi/ori/xori -> zero-extended imm; lui -> {imm,16'b0} with aluc ADD.
REQ-019 e_d = forwarded rt (store data), registered for every instruction.
REQ-020 Forwarding (FWD_EN=1), per source reg r != 0: EX match with ex_wreg & !ex_m2reg -> ex_alu; else MEM match with mm_wreg -> mm_m2reg ? mm_mo : mm_alu; else qa/qb; EX priority over MEM.
REQ-021 Register 0 is never forwarded nor hazard-checked.
REQ-022 Source usage: rs used by all except shifts and lui; rt used by R-type and sw only.
REQ-023 stall=1 when id_valid & !flush and a used source matches ex_rn with ex_wreg & ex_m2reg (load-use); with FWD_EN=0 also on any used-source match with ex_wreg or mm_wreg.
REQ-024 Latency: one cycle; on rising clk with stall=0, flush=0, id_valid=1, decoded fields load into e_* and e_valid=1.
REQ-025 Bubble: stall=1, flush=1 or id_valid=0 loads e_valid=0, e_wreg=0, e_m2reg=0, e_wmem=0, e_aluc=0000, e_rn=0; e_a/e_b/e_d load 0.
REQ-026 flush has priority over stall; stall forced 0 when flush=1.
REQ-027 A stall lasts exactly as long as the hazard condition; after one bubble a load-use hazard resolves via MEM forwarding of mm_mo.

Reset
REQ-028 clrn low asynchronously clears all e_* outputs to 0 (e_valid=0) irrespective of clk, including mid-stall.
REQ-029 First rising clk after clrn high captures ID normally; stall output is combinational and unaffected by reset.

Verification
REQ-030 add $3,$1,$2, qa=5, qb=7, no hazards -> next edge e_aluc=0000, e_a=5, e_b=7, e_rn=3, e_wreg=1, e_valid=1.
REQ-031 sub $4,$3,$1 with ex_wreg=1, ex_rn=3, ex_alu=12, qa=99 -> e_a=12, e_aluc=0100, stall=0.
REQ-032 lw $5 in EX (ex_m2reg=1, ex_rn=5), ID add $6,$5,$0 -> stall=1, next e_valid=0; following cycle mm_rn=5, mm_mo=0x1234 -> e_a=0x1234.
REQ-033 sra $7,$2,3 with qb=0x80000000 -> e_a=3, e_b=0x80000000, e_aluc=1111; lui $8,0xABCD -> e_a=0, e_b=0xABCD0000, e_aluc=0000.
REQ-034 flush=1 together with load-use hazard -> stall=0, next e_valid=0, e_wreg=0; clrn pulse low mid-stream -> all e_* 0 immediately.
REQ-035 FWD_EN=0, ori $9,$3,0xFFFF with mm_wreg=1, mm_rn=3 -> stall=1; once hazard clears -> e_b=0x0000FFFF, e_aluc=0101.
